// File: rtl/conv_stream_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
package conv_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  localparam int TAPS       = 9;
  localparam int COEF_W_DEF = 5;

  typedef logic signed [COEF_W_DEF-1:0] coef_t;
  typedef coef_t kernel_t [TAPS];

endpackage

// File: rtl/conv_line_buffer.sv
// Circular one-line delay: dout is the sample written len_i enables ago.
module conv_line_buffer #(
  parameter int PIX_W = 8,
  parameter int MAX_W = 1024,
  parameter int DIM_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] len_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  localparam int PTR_W = $clog2(MAX_W);

  logic [PIX_W-1:0] mem_q [MAX_W];
  logic [PTR_W-1:0] ptr_q;
  logic [DIM_W-1:0] last;

  assign last   = len_i - DIM_W'(1);
  assign dout_o = mem_q[ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ptr_q <= '0;
    else if (clr_i)  ptr_q <= '0;
    else if (en_i)   ptr_q <= (DIM_W'(ptr_q) == last) ? '0 : ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (en_i) mem_q[ptr_q] <= din_i;
  end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// RGB -> luma -> 3x3 window -> signed kernel, five-stage pipeline with a global
// stall enable driven by output backpressure.
module conv3x3_stream_engine
  import conv_stream_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = COEF_W_DEF,
  parameter int MAX_W  = 1024,
  parameter int DIM_W  = 11
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DIM_W-1:0]               cfg_width,
  input  logic [DIM_W-1:0]               cfg_height,
  input  logic                           coef_we,
  input  logic [3:0]                     coef_addr,
  input  logic signed [COEF_W-1:0]       coef_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIX_W-1:0]               pixel_r,
  input  logic [PIX_W-1:0]               pixel_g,
  input  logic [PIX_W-1:0]               pixel_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [PIX_W+COEF_W+3:0] out_data,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           frame_err
);

  localparam int OUT_W = PIX_W + COEF_W + 4;
  localparam int ACC_W = PIX_W + 8;
  localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(MAX_W);

  state_e                    state_q;
  logic [DIM_W-1:0]          w_q, h_q, x_q, y_q;
  logic signed [COEF_W-1:0]  shadow_q [TAPS];
  logic signed [COEF_W-1:0]  active_q [TAPS];
  logic                      busy_q, frame_done_q, frame_err_q;

  logic                      s1_pix_q, s1_win_q, s2_win_q, s3_win_q, s4_win_q;
  logic [PIX_W-1:0]          s1_luma_q, luma_d;
  logic [PIX_W-1:0]          win_q [TAPS];
  logic signed [OUT_W-1:0]   prod_q [TAPS];
  logic signed [OUT_W-1:0]   prod_d [TAPS];
  logic signed [OUT_W-1:0]   part_q [3];
  logic signed [OUT_W-1:0]   part_d [3];
  logic signed [OUT_W-1:0]   sum_d, out_data_q;
  logic                      out_valid_q;

  logic en, accept, dims_ok, start_ok, drain_done;
  logic [PIX_W-1:0] lb0_out, lb1_out;

  assign en         = !(out_valid_q && !out_ready);
  assign in_ready   = (state_q == RUN) && en;
  assign accept     = in_valid && in_ready;
  assign dims_ok    = (cfg_width >= DIM_W'(3)) && (cfg_width <= MAX_DIM) && (cfg_height >= DIM_W'(3));
  assign start_ok   = (state_q == IDLE) && start && dims_ok;
  assign drain_done = !s1_pix_q && !s2_win_q && !s3_win_q && !s4_win_q && (!out_valid_q || out_ready);

  assign luma_d = PIX_W'((ACC_W'(LUMA_R) * ACC_W'(pixel_r) + ACC_W'(LUMA_G) * ACC_W'(pixel_g)
                        + ACC_W'(LUMA_B) * ACC_W'(pixel_b)) >> 8);

  always_comb begin
    for (int i = 0; i < TAPS; i++)
      prod_d[i] = $signed({{(OUT_W-PIX_W){1'b0}}, win_q[i]})
                * $signed({{(OUT_W-COEF_W){active_q[i][COEF_W-1]}}, active_q[i]});
    for (int r = 0; r < 3; r++)
      part_d[r] = prod_q[3*r] + prod_q[3*r+1] + prod_q[3*r+2];
    sum_d = part_q[0] + part_q[1] + part_q[2];
  end

  // lb0 delays the current row by one line, lb1 by two
  conv_line_buffer #(.PIX_W(PIX_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) u_lb0 (
    .clk(clk), .reset(reset), .clr_i(start_ok), .en_i(en && s1_pix_q),
    .len_i(w_q), .din_i(s1_luma_q), .dout_o(lb0_out));

  conv_line_buffer #(.PIX_W(PIX_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) u_lb1 (
    .clk(clk), .reset(reset), .clr_i(start_ok), .en_i(en && s1_pix_q),
    .len_i(w_q), .din_i(lb0_out), .dout_o(lb1_out));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) shadow_q[i] <= '0;
    end else if (coef_we && (coef_addr <= 4'd8)) begin
      shadow_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) active_q[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            w_q     <= cfg_width;
            h_q     <= cfg_height;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
            for (int i = 0; i < TAPS; i++) active_q[i] <= shadow_q[i];
          end else if (start) begin
            frame_err_q <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (x_q == w_q - DIM_W'(1)) begin
              x_q <= '0;
              y_q <= y_q + DIM_W'(1);
              if (y_q == h_q - DIM_W'(1)) state_q <= DRAIN;
            end else begin
              x_q <= x_q + DIM_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_pix_q    <= 1'b0;
      s1_win_q    <= 1'b0;
      s1_luma_q   <= '0;
      s2_win_q    <= 1'b0;
      s3_win_q    <= 1'b0;
      s4_win_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        win_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) part_q[r] <= '0;
    end else if (en) begin
      s1_pix_q <= accept;
      s1_win_q <= accept && (x_q >= DIM_W'(2)) && (y_q >= DIM_W'(2));
      if (accept) s1_luma_q <= luma_d;
      // window shifts only on real pixels; column 2 is the newest
      if (s1_pix_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[3*r]   <= win_q[3*r+1];
          win_q[3*r+1] <= win_q[3*r+2];
        end
        win_q[2] <= lb1_out;
        win_q[5] <= lb0_out;
        win_q[8] <= s1_luma_q;
      end
      s2_win_q <= s1_win_q;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
      s3_win_q <= s2_win_q;
      for (int r = 0; r < 3; r++) part_q[r] <= part_d[r];
      s4_win_q    <= s3_win_q;
      out_valid_q <= s4_win_q;
      if (s4_win_q) out_data_q <= sum_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Randomised self-checking bench for conv3x3_stream_engine against a direct
// frame-level convolution model.
module tb_conv3x3_stream_engine;

  localparam int PIX_W = 8, COEF_W = 5, DIM_W = 11, OUT_W = 17;

  logic                     clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [DIM_W-1:0]         cfg_width = '0, cfg_height = '0;
  logic                     coef_we = 1'b0;
  logic [3:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     in_valid = 1'b0, in_ready;
  logic [PIX_W-1:0]         pixel_r = '0, pixel_g = '0, pixel_b = '0;
  logic                     out_valid, out_ready = 1'b1;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy, frame_done, frame_err;

  conv3x3_stream_engine dut (
    .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int shadow_k [9], act_k [9], new_k [9];
  int fr_r [256], fr_g [256], fr_b [256];
  int exp_q [$];

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int luma_of(input int i);
    return (77 * fr_r[i] + 150 * fr_g[i] + 29 * fr_b[i]) >> 8;
  endfunction

  function automatic void model_fill(input int w, input int h);
    int s;
    for (int cy = 1; cy < h - 1; cy++)
      for (int cx = 1; cx < w - 1; cx++) begin
        s = 0;
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            s += luma_of((cy + dy - 1) * w + cx + dx - 1) * act_k[dy * 3 + dx];
        exp_q.push_back(s);
      end
  endfunction

  task automatic fill_gray(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      fr_r[i] = v; fr_g[i] = v; fr_b[i] = v;
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      fr_r[i] = int'($urandom_range(0, 255));
      fr_g[i] = int'($urandom_range(0, 255));
      fr_b[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic load_kernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 4'(i); coef_data = 5'(new_k[i]);
      shadow_k[i] = new_k[i];
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h, input bit wr, input int waddr, input int wdata);
    bit ok;
    ok = (w >= 3) && (w <= 1024) && (h >= 3);
    @(negedge clk);
    cfg_width = 11'(w); cfg_height = 11'(h); start = 1'b1;
    if (wr) begin
      coef_we = 1'b1; coef_addr = 4'(waddr); coef_data = 5'(wdata);
    end
    if (ok) act_k = shadow_k;
    if (wr && waddr <= 8) shadow_k[waddr] = wdata;
    @(negedge clk);
    start = 1'b0; coef_we = 1'b0;
    chk("start_err", frame_err, ok ? 0 : 1);
    chk("start_busy", busy, ok ? 1 : 0);
    if (!ok) begin
      @(negedge clk);
      chk("err_pulse_end", frame_err, 0);
      chk("err_busy", busy, 0);
    end
  endtask

  // mode 0: always ready; 1: random in_valid/out_ready; 2: out_ready low 10 cycles at first output
  task automatic run_frame(input int w, input int h, input int mode, input bit mid_wr);
    int n, idx, cyc, acc22, stall_left, prev_data;
    bit finished, first, did_stall, prev_stall, pend_done, wrote;
    n = w * h; idx = 0; cyc = 0; acc22 = -100; stall_left = 0; prev_data = 0;
    finished = 0; first = 1; did_stall = 0; prev_stall = 0; pend_done = 0; wrote = 0;
    while (!finished && cyc < 40 * n + 100) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (pend_done) begin
        chk("done_timing", frame_done, 1);
        pend_done = 0;
      end
      if (frame_done) begin
        chk("done_empty", exp_q.size(), 0);
        chk("done_count", idx, n);
        chk("done_busy", busy, 0);
        finished = 1;
      end else begin
        if (mode == 2 && out_valid && !did_stall) begin
          stall_left = 10; did_stall = 1;
        end
        if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else           out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        in_valid = (idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
        if (idx < n) begin
          pixel_r = 8'(fr_r[idx]); pixel_g = 8'(fr_g[idx]); pixel_b = 8'(fr_b[idx]);
        end
        coef_we = 1'b0;
        if (mid_wr && !wrote && idx >= n / 2) begin
          coef_we = 1'b1; coef_addr = 4'd4; coef_data = 5'sd3;
          shadow_k[4] = 3; wrote = 1;
        end
        #1;
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (mode != 1 && out_valid && first) begin
          chk("latency", cyc - acc22, 5);
          first = 0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("extra_output", 1, 0);
          else begin
            chk("out_data", out_data, exp_q.pop_front());
            if (exp_q.size() == 0) pend_done = 1;
          end
        end
        if (in_valid && in_ready) begin
          if (idx == 2 * w + 2) acc22 = cyc;
          idx++;
        end
      end
    end
    if (!finished) chk("frame_timeout", 0, 1);
    in_valid = 1'b0; out_ready = 1'b1; coef_we = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h;
    for (int i = 0; i < 9; i++) begin shadow_k[i] = 0; act_k[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    reset = 1'b1;

    // flat 4x4 frame, box kernel
    for (int i = 0; i < 9; i++) new_k[i] = 1;
    load_kernel();
    fill_gray(16, 10);
    start_frame(4, 4, 0, 0, 0);
    exp_q = '{90, 90, 90, 90};
    run_frame(4, 4, 0, 0);

    // ramp through identity kernel
    for (int i = 0; i < 9; i++) new_k[i] = 0;
    new_k[4] = 1;
    load_kernel();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        fr_r[y*5+x] = x + 5*y; fr_g[y*5+x] = x + 5*y; fr_b[y*5+x] = x + 5*y;
      end
    start_frame(5, 5, 0, 0, 0);
    exp_q = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    run_frame(5, 5, 1, 0);

    // impulse through Laplacian
    for (int i = 0; i < 9; i++) new_k[i] = -1;
    new_k[4] = 8;
    load_kernel();
    fill_gray(25, 0);
    fill_gray(0, 0);
    fr_r[12] = 255; fr_g[12] = 255; fr_b[12] = 255;
    start_frame(5, 5, 0, 0, 0);
    exp_q = '{-255, -255, -255, -255, 2040, -255, -255, -255, -255};
    run_frame(5, 5, 0, 0);

    // flat frame with a 10-cycle output stall
    for (int i = 0; i < 9; i++) new_k[i] = 1;
    load_kernel();
    fill_gray(16, 10);
    start_frame(4, 4, 0, 0, 0);
    exp_q = '{90, 90, 90, 90};
    run_frame(4, 4, 2, 0);

    // mid-frame shadow write only reaches the next frame
    fill_random(25);
    start_frame(5, 5, 0, 0, 0);
    model_fill(5, 5);
    run_frame(5, 5, 0, 1);
    chk("shadow_c4", shadow_k[4], 3);
    fill_random(25);
    start_frame(5, 5, 0, 0, 0);
    model_fill(5, 5);
    run_frame(5, 5, 0, 0);

    // random frames, random kernels, coefficient write racing the start
    for (int f = 0; f < 6; f++) begin
      w = int'($urandom_range(3, 12));
      h = int'($urandom_range(3, 8));
      for (int i = 0; i < 9; i++) new_k[i] = int'($urandom_range(0, 31)) - 16;
      load_kernel();
      fill_random(w * h);
      start_frame(w, h, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)) - 16);
      model_fill(w, h);
      run_frame(w, h, 1, 0);
    end

    // illegal dimensions
    start_frame(2, 5, 0, 0, 0);
    start_frame(5, 2, 0, 0, 0);
    start_frame(1025, 4, 0, 0, 0);

    // reset in the middle of a frame
    fill_random(36);
    start_frame(6, 6, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      pixel_r = 8'(fr_r[c]); pixel_g = 8'(fr_g[c]); pixel_b = 8'(fr_b[c]);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_err", frame_err, 0);
    for (int i = 0; i < 9; i++) begin shadow_k[i] = 0; act_k[i] = 0; end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start_frame(2, 5, 0, 0, 0);

    // kernels were cleared by reset, so every result is zero
    fill_random(12);
    start_frame(4, 3, 0, 0, 0);
    model_fill(4, 3);
    run_frame(4, 3, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
